// File: rtl/game_pkg.sv
// Types and constants shared by the obstacle, player and game-logic blocks.
// Holds the FSM states, the LFSR tap mask and the default screen geometry.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int GAME_X_W     = 8;
    localparam int GAME_Y_W     = 2;
    localparam int GAME_X_START = 159;
    localparam int GAME_X_END   = 0;

    // One Galois shift: drop the LSB and fold it back through the tap mask.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used as the lane picker.
// A zero seed is replaced by 1 so the register can never lock up at zero.
module lfsr16
    import game_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_lfsr <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign out = r_lfsr;

endmodule

// File: rtl/obstacle_driver.sv
// Obstacle position generator: scrolls one obstacle right-to-left at a
// tick-divided rate, respawns it in a pseudo-random lane and speeds up over time.
//
// state   | meaning
// IDLE    | waiting for start, obstacle parked at the spawn column
// RUN     | scrolling; ticks advance the divider and step the obstacle
// HALT    | frozen after gameOver until restart or reset
module obstacle_driver
    import game_pkg::*;
#(
    parameter int          X_W           = GAME_X_W,
    parameter int          Y_W           = GAME_Y_W,
    parameter int          X_START       = GAME_X_START,
    parameter int          X_END         = GAME_X_END,
    parameter int          STEP_INIT     = 8,
    parameter int          STEP_MIN      = 2,
    parameter int          SPEEDUP_EVERY = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           restart,
    input  logic           start,
    input  logic           tick,
    input  logic           gameOver,
    output logic [X_W-1:0] obstacleX,
    output logic [Y_W-1:0] obstacleY,
    output logic           spawn,
    output logic           running,
    output logic [3:0]     level
);

    localparam int CNT_W = (STEP_INIT < 2) ? 1 : $clog2(STEP_INIT + 1);
    localparam int WR_W  = (SPEEDUP_EVERY < 2) ? 1 : $clog2(SPEEDUP_EVERY + 1);

    localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(STEP_INIT);
    localparam logic [CNT_W-1:0] PERIOD_MIN  = CNT_W'(STEP_MIN);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [WR_W-1:0]  WRAPS_LAST  = WR_W'(SPEEDUP_EVERY - 1);
    localparam logic [X_W-1:0]   X_START_V   = X_W'(X_START);
    localparam logic [X_W-1:0]   X_END_V     = X_W'(X_END);

    state_e           r_state;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic             r_spawn;
    logic [3:0]       r_level;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_period;
    logic [WR_W-1:0]  r_wraps;

    logic [15:0]      w_lfsr;
    logic [Y_W-1:0]   w_lane;

    lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .seed  (LFSR_SEED),
        .out   (w_lfsr)
    );

    assign w_lane = Y_W'(w_lfsr);

    // Restart reinitialises everything here; only the LFSR keeps its history.
    always_ff @(posedge clock) begin
        if (!reset || restart) begin
            r_state  <= ST_IDLE;
            r_x      <= X_START_V;
            r_y      <= '0;
            r_spawn  <= 1'b0;
            r_level  <= 4'd0;
            r_div    <= '0;
            r_period <= PERIOD_INIT;
            r_wraps  <= '0;
        end else begin
            r_spawn <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_x     <= X_START_V;
                        r_y     <= w_lane;
                        r_spawn <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (gameOver) begin
                        r_state <= ST_HALT;
                    end else if (tick) begin
                        if (r_div == r_period - CNT_ONE) begin
                            r_div <= '0;
                            if (r_x != X_END_V) begin
                                r_x <= r_x - X_W'(1);
                            end else begin
                                r_x     <= X_START_V;
                                r_y     <= w_lane;
                                r_spawn <= 1'b1;
                                if (r_wraps == WRAPS_LAST) begin
                                    r_wraps <= '0;
                                    if (r_period > PERIOD_MIN) r_period <= r_period - CNT_ONE;
                                    if (r_level != 4'hF) r_level <= r_level + 4'd1;
                                end else begin
                                    r_wraps <= r_wraps + WR_W'(1);
                                end
                            end
                        end else begin
                            r_div <= r_div + CNT_ONE;
                        end
                    end
                end
                ST_HALT: ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign obstacleX = r_x;
    assign obstacleY = r_y;
    assign spawn     = r_spawn;
    assign running   = (r_state == ST_RUN);
    assign level     = r_level;

endmodule

// File: doc/obstacle_driver.md
Name: obstacle_driver

Overview:
Producer side of the game collision/score logic. It generates the obstacle position stream (obstacleX, obstacleY) that the game logic compares against the player position. Obstacles scroll right-to-left at a tick-divided rate and respawn in a pseudo-random lane. The scroll rate speeds up as obstacles pass, and all motion freezes on gameOver until restart.

Parameters:
X_W, 8, obstacleX width
Y_W, 2, obstacleY (lane) width; all 2^Y_W lanes valid
X_START, 159, spawn column (right edge)
X_END, 0, last column before wrap
STEP_INIT, 8, ticks per one-column step at level 0
STEP_MIN, 2, floor for ticks per step
SPEEDUP_EVERY, 4, wraps per level increment
LFSR_SEED, 16'hACE1, LFSR reset value (0 is replaced by 1)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset
restart  in  1  return to IDLE without reseeding the LFSR
start  in  1  begin scrolling from IDLE
tick  in  1  frame strobe, 1 cycle wide
gameOver  in  1  collision flag from game logic
obstacleX  out  X_W  current obstacle column (registered)
obstacleY  out  Y_W  current obstacle lane (registered)
spawn  out  1  1-cycle pulse when a new obstacle is placed
running  out  1  1 only in RUN
level  out  4  speed level, saturates at 15

Behaviour:
- States: IDLE, RUN, HALT.
- Priority per cycle: reset==0 > restart > gameOver > start/tick.
- Reset (reset==0 at posedge) sets:
  - state=IDLE, obstacleX=X_START, obstacleY=0, spawn=0, running=0, level=0
  - divider=0, period=STEP_INIT, wrap count=0, lfsr=LFSR_SEED (or 1 if the seed is 0)
- restart: same values as reset, except the LFSR keeps running so successive games differ.
- LFSR:
  - 16-bit Galois, tap mask 16'hB400.
  - Advances every clock in every state except during reset.
  - Never reaches all-zero.
- IDLE:
  - start=1 -> RUN.
  - On the same edge: obstacleX=X_START, obstacleY=lfsr[Y_W-1:0], spawn=1 for the next cycle.
- RUN, tick=1:
  - If divider==period-1: divider<=0 and a step occurs. Otherwise divider<=divider+1.
  - tick=0: divider holds.
- Step:
  - obstacleX<=obstacleX-1 when obstacleX!=X_END.
  - When obstacleX==X_END (wrap): obstacleX<=X_START, obstacleY<=lfsr[Y_W-1:0], spawn=1 for one cycle, wrap count++.
- Speed-up: when a wrap brings the wrap count to SPEEDUP_EVERY:
  - wrap count<=0
  - period<=max(period-1, STEP_MIN)
  - level<=min(level+1, 15)
- Latency: outputs change one cycle after the qualifying tick edge.
- gameOver=1 in RUN -> HALT on that edge.
  - No step occurs that cycle, even if the tick would have stepped.
  - Positions and level freeze.
- HALT:
  - running=0; ticks, start and gameOver are ignored.
  - Exit only via restart or reset, both -> IDLE.
- start outside IDLE is ignored. gameOver in IDLE is ignored.
- spawn is never high for two consecutive cycles.
- Reset mid-run: all reset values appear on the next cycle regardless of state.

Decomposition:
- Shared package game_pkg holds:
  - the state enum (IDLE/RUN/HALT)
  - the LFSR tap constant 16'hB400
  - the default X_W/Y_W and screen-edge constants, shared with the player and game-logic blocks
- Sub-module lfsr16:
  - Ports: clock, reset, seed, out.
  - Free-running Galois LFSR with the zero-seed guard.

Test Plan:
1. reset=0 for 1 cycle -> obstacleX=159, obstacleY=0, running=0, level=0, spawn=0; lfsr equals 16'hACE1.
2. start, then 8 ticks -> obstacleX=158 one cycle after the 8th tick; after 16 ticks -> 157; no change on non-tick cycles.
3. X_START=3: run to wrap -> X sequence 3,2,1,0,3; spawn high exactly one cycle at the wrap; obstacleY equals the lfsr low bits sampled at that edge.
4. Four wraps -> level=1 and the next step takes 7 ticks; continued play -> period floors at 2; level saturates at 15.
5. gameOver at obstacleX=100 -> X stays 100 over 50 ticks, running=0. restart -> IDLE, X=159, level=0, LFSR not reseeded.
6. Edge cases:
   - gameOver on the same cycle as a stepping tick -> no move, state=HALT.
   - reset=0 asserted mid-RUN -> reset values next cycle.
   - start during HALT -> ignored.
